// File: rtl/varredura_matriz.sv
// varredura_matriz: row-scan driver for a 5x7 LED matrix; define VARREDURA_BLANK_EN for a one-cycle dark gap at the start of each row slot
module varredura_matriz #(
    parameter int DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [34:0] mapa,
    output logic [6:0]  linha,
    output logic [4:0]  coluna,
    output logic        frame_fim
);
    localparam int PW = $clog2(DIV);
`ifdef VARREDURA_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    typedef enum logic {DESL, ATIVO} estado_t;
    estado_t        estado_q;
    logic [2:0]     row_q, row_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [34:0]    snap_q, snap_d;
    logic [6:0]     linha_q;
    logic [4:0]     coluna_q;
    logic           fim_q;
    logic           scan, fim_slot, lit_d;
    // next scan position and snapshot; en low forces everything back to the top row
    always_comb begin
        scan     = estado_q == ATIVO && en;
        fim_slot = presc_q == PW'(DIV - 1);
        presc_d  = scan && !fim_slot ? presc_q + 1'b1 : '0;
        row_d    = !scan ? 3'd0 : !fim_slot ? row_q : row_q == 3'd6 ? 3'd0 : row_q + 3'd1;
        snap_d   = en && (estado_q == DESL || (fim_slot && row_q == 3'd6)) ? mapa : snap_q;
        lit_d    = en && !(BLANK && presc_d == '0);
    end
    // state and outputs registered together, outputs computed from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= DESL;
            row_q    <= '0;
            presc_q  <= '0;
            snap_q   <= '0;
            linha_q  <= '0;
            coluna_q <= 5'b11111;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= en ? ATIVO : DESL;
            row_q    <= row_d;
            presc_q  <= presc_d;
            snap_q   <= snap_d;
            linha_q  <= lit_d ? 7'd1 << row_d : 7'd0;
            coluna_q <= lit_d ? ~snap_d[5*row_d +: 5] : 5'b11111;
            fim_q    <= en && row_d == 3'd6 && presc_d == PW'(DIV - 1);
        end
    end
    assign linha     = linha_q;
    assign coluna    = coluna_q;
    assign frame_fim = fim_q;
endmodule

// File: tb/tb_varredura_matriz.sv
// tb_varredura_matriz: table, hand-sequence and random checks of varredura_matriz against a time-based model
module tb_varredura_matriz;
    localparam int DIV = 4;
`ifdef VARREDURA_BLANK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [34:0] mapa = '1;
    logic [6:0]  linha;
    logic [4:0]  coluna;
    logic        frame_fim;
    int total = 0;
    int bad = 0;
    int cyc;
    bit m_act = 1'b0;
    int k = 0;
    logic [34:0] m_snap = '0;

    typedef struct {
        int         cyc;
        logic [6:0] l;
        logic [4:0] c;
        logic       f;
    } vec_t;
    vec_t tab[10];

    varredura_matriz #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mapa(mapa),
        .linha(linha), .coluna(coluna), .frame_fim(frame_fim)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: k counts cycles since the scan started, row/slot derived by division
    task automatic model_edge();
        if (!en) m_act = 1'b0;
        else if (!m_act) begin
            m_act = 1'b1;
            k = 0;
            m_snap = mapa;
        end else begin
            k++;
            if (k % (7 * DIV) == 0) m_snap = mapa;
        end
    endtask

    task automatic model_chk();
        int r, p;
        bit lit;
        logic [6:0] el;
        logic [4:0] ec;
        logic ef;
        r = (k / DIV) % 7;
        p = k % DIV;
        lit = m_act && !(BL && p == 0);
        el = lit ? 7'(1 << r) : 7'd0;
        ec = lit ? ~m_snap[5*r +: 5] : 5'b11111;
        ef = m_act && r == 6 && p == DIV - 1;
        chk("model_linha", 32'(linha), 32'(el));
        chk("model_coluna", 32'(coluna), 32'(ec));
        chk("model_frame_fim", 32'(frame_fim), 32'(ef));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_chk();
        cyc++;
    endtask

    task automatic restart(input logic [34:0] m);
        en = 1'b0;
        step();
        en = 1'b1;
        mapa = m;
        cyc = 0;
    endtask

    initial begin
        tab[0] = '{2,  7'h01, 5'h00, 1'b0};
        tab[1] = '{4,  7'h01, 5'h00, 1'b0};
        tab[2] = '{6,  7'h02, 5'h1F, 1'b0};
        tab[3] = '{8,  7'h02, 5'h1F, 1'b0};
        tab[4] = '{12, 7'h04, 5'h1F, 1'b0};
        tab[5] = '{24, 7'h20, 5'h1F, 1'b0};
        tab[6] = '{27, 7'h40, 5'h1F, 1'b0};
        tab[7] = '{28, 7'h40, 5'h1F, 1'b1};
        tab[8] = '{30, 7'h01, 5'h00, 1'b0};
        tab[9] = '{56, 7'h40, 5'h1F, 1'b1};
        // reset held with en=1 and a full map
        repeat (3) @(posedge clk);
        #1;
        chk("rst_linha", 32'(linha), 32'h0);
        chk("rst_coluna", 32'(coluna), 32'h1F);
        chk("rst_frame_fim", 32'(frame_fim), 32'h0);
        mapa = 35'h1F;
        rst_n = 1'b1;
        cyc = 0;
        step();
        chk("rst_release_row0", 32'(linha), BL ? 32'h0 : 32'h1);
        for (int i = 0; i < 10; i++) begin
            while (cyc < tab[i].cyc) step();
            chk($sformatf("tab%0d_linha", i), 32'(linha), 32'(tab[i].l));
            chk($sformatf("tab%0d_coluna", i), 32'(coluna), 32'(tab[i].c));
            chk($sformatf("tab%0d_frame_fim", i), 32'(frame_fim), 32'(tab[i].f));
        end
        // snapshot: map change during row 3 is hidden until the next frame
        restart(35'h1F);
        while (cyc < 14) step();
        mapa = 35'h7C0000000;
        while (cyc < 26) step();
        chk("snap_old_row6", 32'(coluna), 32'h1F);
        while (cyc < 30) step();
        chk("snap_new_row0", 32'(coluna), 32'h1F);
        while (cyc < 54) step();
        chk("snap_new_row6", 32'(coluna), 32'h00);
        // abort during row 3, then re-enable with the current map
        restart(35'h1F);
        while (cyc < 14) step();
        en = 1'b0;
        step();
        chk("abort_linha", 32'(linha), 32'h0);
        chk("abort_coluna", 32'(coluna), 32'h1F);
        chk("abort_frame_fim", 32'(frame_fim), 32'h0);
        en = 1'b1;
        step();
        step();
        chk("reen_row0", 32'(linha), 32'h1);
        chk("reen_coluna", 32'(coluna), 32'h00);
        // en dropped on the wrap edge: frame_fim still seen, then off
        restart(35'h1F);
        while (cyc < 28) step();
        chk("wrap_frame_fim", 32'(frame_fim), 32'h1);
        en = 1'b0;
        step();
        chk("wrap_off", 32'(linha), 32'h0);
        en = 1'b1;
        // async reset between edges during row 5
        restart(35'h155555555);
        while (cyc < 22) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_linha", 32'(linha), 32'h0);
        chk("arst_coluna", 32'(coluna), 32'h1F);
        chk("arst_frame_fim", 32'(frame_fim), 32'h0);
        m_act = 1'b0;
        #1 rst_n = 1'b1;
        step();
        step();
        chk("arst_restart_row0", 32'(linha), 32'h1);
        // random enable and map traffic
        for (int i = 0; i < 800; i++) begin
            en = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 3) == 0) mapa = 35'({$urandom, $urandom});
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
